// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC fetch controller: FSM state encoding,
// reset/NOP constants and small address helpers.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_S = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when a byte address is not word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of the fetch controller's control, instruction-memory and decode-side
// signals. The master modport is the fetch controller itself; the slave
// modport is the surrounding pipeline / memory.
// Optional build macro: MISALIGN_TRAP_EN adds the misalign_trap signal.
interface pc_fetch_ctrl_if;

  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  modport master (
    input  stall, redir_valid, redir_addr, imem_ack, imem_rdata,
`ifdef MISALIGN_TRAP_EN
    output misalign_trap,
`endif
    output imem_req, imem_addr, if_valid, if_pc, if_instr, flush
  );

  modport slave (
    output stall, redir_valid, redir_addr, imem_ack, imem_rdata,
`ifdef MISALIGN_TRAP_EN
    input  misalign_trap,
`endif
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, flush
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register for the fetch controller. Catches an instruction
// word that returns from memory while decode is stalled so it is neither
// lost nor re-fetched. Clear (redirect) has priority over push and pop.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic        o_full,
  output logic [31:0] o_data
);

  logic        r_full;
  logic [31:0] r_data;

  // Track occupancy and capture the buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= 32'h0000_0000;
    end else if (i_clear) begin
      r_full <= 1'b0;
      r_data <= 32'h0000_0000;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
      r_data <= r_data;
    end else begin
      r_full <= r_full;
      r_data <= r_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one instruction-memory
// request at a time, hands fetched words to decode, and handles stalls and
// branch/jump redirects (dropping a stale in-flight word when needed).
// Optional build macro: MISALIGN_TRAP_EN. When defined, a redirect to a
// non-word-aligned target raises misalign_trap and halts fetch until the
// next redirect; otherwise the low two target bits are simply cleared.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master fc
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_imem_req;
  logic         r_if_valid;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_instr;
  logic         r_flush;
  logic         r_halt;
`ifdef MISALIGN_TRAP_EN
  logic         r_trap;
`endif

  logic         w_ack_take;
  logic         w_ack_drop;
  logic         w_redir_bad;
  logic [31:0]  w_redir_pc;
  logic [31:0]  w_pc_next;
  logic         w_skid_push;
  logic         w_skid_pop;
  logic         w_skid_full;
  logic [31:0]  w_skid_data;

  // Qualify memory acks against our own request and resolve the redirect target.
  always_comb begin
    w_ack_take = r_imem_req & fc.imem_ack;
    w_ack_drop = (r_state == DROP) & fc.imem_ack;
    w_pc_next  = r_pc + PC_STEP;
`ifdef MISALIGN_TRAP_EN
    w_redir_bad = fc.redir_valid & is_misaligned(fc.redir_addr);
    w_redir_pc  = fc.redir_addr;
`else
    w_redir_bad = 1'b0;
    w_redir_pc  = align_word(fc.redir_addr);
`endif
    w_skid_push = (r_state == FETCH) & fc.stall & w_ack_take & ~fc.redir_valid;
    w_skid_pop  = (r_state == FETCH) & ~fc.stall & w_skid_full & ~fc.redir_valid;
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_clear (fc.redir_valid),
    .i_data  (fc.imem_rdata),
    .o_full  (w_skid_full),
    .o_data  (w_skid_data)
  );

  // Fetch FSM with PC, request and decode-side outputs all registered.
  // if_instr reads 0 while in reset/RST_S and INSTR_NOP on any later bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_S;
      r_pc       <= RESET_PC;
      r_imem_req <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= 32'h0000_0000;
      r_flush    <= 1'b0;
      r_halt     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_trap     <= 1'b0;
`endif
    end else begin
      r_flush <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      r_trap  <= 1'b0;
`endif
      if (fc.redir_valid) begin
        // Redirect beats stall and ack: kill the IF/ID word and retarget.
        r_flush    <= 1'b1;
        r_if_valid <= 1'b0;
        r_if_instr <= INSTR_NOP;
        if (w_redir_bad) begin
          r_halt <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          r_trap <= 1'b1;
`endif
        end else begin
          r_pc   <= w_redir_pc;
          r_halt <= 1'b0;
        end
        case (r_state)
          FETCH: begin
            if (r_imem_req && !fc.imem_ack) begin
              // Old request still in flight: its word must be thrown away.
              r_state    <= DROP;
              r_imem_req <= 1'b0;
            end else begin
              r_state    <= FETCH;
              r_imem_req <= ~w_redir_bad;
            end
          end
          DROP: begin
            if (w_ack_drop) begin
              // The stale word arrives now, so nothing is left to drop.
              r_state    <= FETCH;
              r_imem_req <= ~w_redir_bad;
            end else begin
              r_state    <= DROP;
              r_imem_req <= 1'b0;
            end
          end
          RST_S: begin
            r_state    <= FETCH;
            r_imem_req <= ~w_redir_bad;
          end
          default: begin
            r_state    <= RST_S;
            r_imem_req <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          RST_S: begin
            r_state    <= FETCH;
            r_imem_req <= ~r_halt;
            r_if_instr <= INSTR_NOP;
          end
          FETCH: begin
            r_state <= FETCH;
            if (fc.stall) begin
              // Decode busy: hold everything; a returning word goes to the skid.
              if (w_ack_take) begin
                r_imem_req <= 1'b0;
              end else begin
                r_imem_req <= r_imem_req;
              end
            end else if (w_skid_full) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_instr <= w_skid_data;
              r_pc       <= w_pc_next;
              r_imem_req <= ~r_halt;
            end else if (w_ack_take) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_instr <= fc.imem_rdata;
              r_pc       <= w_pc_next;
              r_imem_req <= ~r_halt;
            end else begin
              // Previous word consumed and nothing new: present a bubble.
              r_if_valid <= 1'b0;
              r_if_instr <= INSTR_NOP;
              r_imem_req <= ~r_halt;
            end
          end
          DROP: begin
            if (w_ack_drop) begin
              r_state    <= FETCH;
              r_imem_req <= ~r_halt;
            end else begin
              r_state    <= DROP;
              r_imem_req <= 1'b0;
            end
          end
          default: begin
            r_state    <= RST_S;
            r_imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fc.imem_req  = r_imem_req;
  assign fc.imem_addr = r_pc;
  assign fc.if_valid  = r_if_valid;
  assign fc.if_pc     = r_if_pc;
  assign fc.if_instr  = r_if_instr;
  assign fc.flush     = r_flush;
`ifdef MISALIGN_TRAP_EN
  assign fc.misalign_trap = r_trap;
`endif

endmodule
